cmp_tally: RTL and testbench
============================

# cmp_tally

Downstream result stage for the 2-bit magnitude comparator `c_dig`. It samples the comparator's F1 (A>B), F2 (A=B) and F3 (A<B) outputs under a valid/ready handshake and re-issues each accepted result as an encoded, registered output. It keeps saturating tallies per outcome and flags runs of identical outcomes. It is the first clocked stage after the combinational comparator and feeds the reporting/monitor logic.

## Interface
- CNT_W, default 8: width of each tally counter; saturating.
- RUN_LEN, default 4: number of consecutive identical outcomes that raise `run_flag`; legal range 2..15.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  reset: synchronous, active-low; sampled on the rising edge of `clk`.
- clear  in  1  synchronous soft clear; same effect as reset on all state.
- in_valid  in  1  F1/F2/F3 hold a result to accept.
- in_ready  out  1  block can accept this cycle.
- F1  in  1  comparator A>B.
- F2  in  1  comparator A=B.
- F3  in  1  comparator A<B.
- out_valid  out  1  `out_code` holds a result.
- out_ready  in  1  consumer accepts `out_code` this cycle.
- out_code  out  2  encoded result: 01 GT, 10 EQ, 11 LT, 00 ERR.
- gt_cnt  out  CNT_W  count of accepted GT results.
- eq_cnt  out  CNT_W  count of accepted EQ results.
- lt_cnt  out  CNT_W  count of accepted LT results.
- err_cnt  out  CNT_W  count of accepted non-one-hot results; present only with CMP_TALLY_ERR_CHK_EN, otherwise tied to 0.
- run_flag  out  1  one-cycle pulse when a run of RUN_LEN identical outcomes completes.
- state  out  2  FSM state, for debug: 00 IDLE, 01 TRACK, 10 STREAK, 11 ERR.

## Operation
- **Accept:** a result is accepted when `in_valid && in_ready`. The ready signal is `in_ready = !out_valid || out_ready`, a single output register with pass-through ready.
- **Decode:** F1-only gives GT, F2-only gives EQ, F3-only gives LT. Any other pattern is handled as defined under Configuration.
- **Tally:** on accept, the matching counter increments by 1. At 2^CNT_W-1 the counter holds and does not wrap.
- **Run tracker:** `run_cnt` is 4 bits.
  - On accept of a code equal to the last code, `run_cnt` increments, saturating at RUN_LEN.
  - On accept of a different code, `run_cnt` is set to 1.
  - An ERR result sets `run_cnt` to 0.
- **run_flag:** pulses on the cycle in which `run_cnt` first becomes RUN_LEN.
- **FSM transitions (evaluated on accept only):**
  - IDLE: valid code goes to TRACK; ERR goes to ERR.
  - TRACK: when `run_cnt` reaches RUN_LEN, go to STREAK; otherwise stay in TRACK.
  - STREAK: same code stays in STREAK with no further pulse; a different code goes to TRACK.
  - Any state: ERR goes to ERR.
  - ERR is sticky. Later valid codes are still tallied and issued, but the state remains ERR until `clear` or reset.
- **Clear:** `clear` zeroes all counters and `run_cnt`, forces the FSM to IDLE, and drops any pending `out_valid`. A result presented in the same cycle as `clear` is discarded.

## Timing
- Reset values: out_valid=0, out_code=00, all counters 0, run_flag=0, state=IDLE. `in_ready` is 1 one cycle after reset, since it is driven combinationally from `out_valid`=0.
- Latency: a result accepted at edge N appears on `out_code`, with `out_valid`=1, after edge N. The counters, state and `run_flag` update at the same edge N.
- `out_code` is held stable while `out_valid && !out_ready`, and `in_ready`=0 during that time.
- Simultaneous `out_ready` and a new accept: the output register reloads at the same edge. No bubble; one result per cycle is sustainable.
- `run_flag` is high for exactly one cycle, coincident with the first `out_valid` cycle of the completing result.
- Precedence: `rst_n` low beats `clear`, and `clear` beats accept. Reset or clear in the middle of a stall discards the held result.

## Configuration
- Macro: CMP_TALLY_ERR_CHK_EN.
- **Defined:** any non-one-hot F1/F2/F3 pattern (000, 011, 101, 110, 111) is accepted as ERR.
  - It increments `err_cnt` and issues `out_code` 00.
  - It resets `run_cnt` and moves the FSM to ERR.
- **Undefined:**
  - Decode uses priority F1 > F2 > F3.
  - An all-zero pattern is accepted but dropped: no count, no output, and the run and state are unchanged.
  - `err_cnt` is 0, and the ERR state is unreachable.

## Test plan
- Sweep all 16 comparator operand pairs (A,B ∈ 0..3) with `out_ready`=1 → gt_cnt=6, eq_cnt=4, lt_cnt=6, and `out_code` matches each pair one cycle after accept.
- Four consecutive EQ results with RUN_LEN=4 → `run_flag` pulses once on the 4th output and state=STREAK. A 5th EQ gives no pulse. A following GT gives state=TRACK.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, `out_code` stable, counters advance by 1 only. Release → back-to-back accepts with no bubble.
- CNT_W=2, five GT results → gt_cnt saturates at 3.
- With CMP_TALLY_ERR_CHK_EN defined, apply F=110 → err_cnt=1, out_code=00, state=ERR. A subsequent GT is tallied but state stays ERR. `clear` → all zero, state=IDLE.
- Assert `clear` while `out_valid` is stalled and `in_valid`=1 → next cycle out_valid=0, the presented result is not counted, and state=IDLE.

Source files
------------

// File: rtl/cmp_tally_if.sv
// cmp_tally_if: handshake bus between the comparator-side producer, the
// cmp_tally result stage and its downstream consumer.
//   slave  - the cmp_tally view (accepts F1/F2/F3, issues out_code)
//   master - the producer/consumer view (testbench or surrounding logic)
interface cmp_tally_if;
    logic       in_valid;
    logic       in_ready;
    logic       F1;
    logic       F2;
    logic       F3;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_code;

    modport slave (
        input  in_valid, F1, F2, F3, out_ready,
        output in_ready, out_valid, out_code
    );

    modport master (
        output in_valid, F1, F2, F3, out_ready,
        input  in_ready, out_valid, out_code
    );
endinterface

// File: rtl/cmp_tally.sv
// cmp_tally: registered result stage behind the 2-bit comparator c_dig.
// Accepts F1/F2/F3 under valid/ready, re-issues an encoded code
// (01 GT, 10 EQ, 11 LT, 00 ERR), keeps saturating per-outcome tallies and
// flags runs of RUN_LEN identical outcomes.
// Optional feature macro: CMP_TALLY_ERR_CHK_EN (non-one-hot inputs become
// ERR results with their own tally and a sticky ERR state). Without it,
// decode is priority F1 > F2 > F3 and an all-zero input is silently dropped.
module cmp_tally #(
    parameter int CNT_W   = 8,
    parameter int RUN_LEN = 4   // legal 2..15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    cmp_tally_if.slave       bus,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             run_flag,
    output logic [1:0]       state
);
    localparam logic [1:0] C_ERR = 2'b00;
    localparam logic [1:0] C_GT  = 2'b01;
    localparam logic [1:0] C_EQ  = 2'b10;
    localparam logic [1:0] C_LT  = 2'b11;
    localparam logic [3:0] RUN_MAX = 4'(RUN_LEN);

    typedef enum logic [1:0] {S_IDLE = 2'b00, S_TRACK = 2'b01,
                              S_STREAK = 2'b10, S_ERR = 2'b11} st_t;

    st_t        st, st_nxt;
    logic [1:0] code, last_code;
    logic [3:0] run_cnt, run_nxt;
    logic       acc, take, drop, is_err, same, flag_nxt;
    logic       out_valid_q;
    logic [1:0] out_code_q;

    // single output register: ready passes through when the consumer drains it
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_code  = out_code_q;
    assign acc           = bus.in_valid && bus.in_ready;
    assign take          = acc && !drop;
    assign state         = st;

    // decode comparator flags into a result code
    always_comb begin
        code   = C_ERR;
        drop   = 1'b0;
        is_err = 1'b0;
`ifdef CMP_TALLY_ERR_CHK_EN
        unique case ({bus.F1, bus.F2, bus.F3})
            3'b100:  code = C_GT;
            3'b010:  code = C_EQ;
            3'b001:  code = C_LT;
            default: begin
                code   = C_ERR;
                is_err = 1'b1;
            end
        endcase
`else
        if (bus.F1)      code = C_GT;
        else if (bus.F2) code = C_EQ;
        else if (bus.F3) code = C_LT;
        else             drop = 1'b1;
`endif
    end

    // run length tracking and completion detection
    always_comb begin
        same     = (code == last_code);
        run_nxt  = run_cnt;
        flag_nxt = 1'b0;
        if (is_err)
            run_nxt = 4'd0;
        else if (same)
            run_nxt = (run_cnt >= RUN_MAX) ? RUN_MAX : run_cnt + 4'd1;
        else
            run_nxt = 4'd1;
        flag_nxt = take && !is_err && same && (run_cnt == RUN_MAX - 4'd1);
    end

    // FSM next state, evaluated only on an accepted (non-dropped) result
    always_comb begin
        st_nxt = st;
        if (take) begin
            if (is_err) begin
                st_nxt = S_ERR;
            end else begin
                unique case (st)
                    S_IDLE:   st_nxt = S_TRACK;
                    S_TRACK:  if (run_nxt == RUN_MAX) st_nxt = S_STREAK;
                    S_STREAK: if (!same) st_nxt = S_TRACK;
                    S_ERR:    st_nxt = S_ERR;
                endcase
            end
        end
    end

    // FSM state register; clear acts exactly like reset
    always_ff @(posedge clk) begin
        if (!rst_n || clear) st <= S_IDLE;
        else                 st <= st_nxt;
    end

    // output register, run tracker and GT/EQ/LT tallies
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            out_valid_q <= 1'b0;
            out_code_q  <= C_ERR;
            last_code   <= C_ERR;
            run_cnt     <= 4'd0;
            run_flag    <= 1'b0;
            gt_cnt      <= '0;
            eq_cnt      <= '0;
            lt_cnt      <= '0;
        end else begin
            run_flag <= flag_nxt;
            if (acc) begin
                // a dropped input still drains the register but issues nothing
                out_valid_q <= !drop;
                if (!drop) out_code_q <= code;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (take) begin
                last_code <= code;
                run_cnt   <= run_nxt;
                unique case (code)
                    C_GT:    if (gt_cnt != '1) gt_cnt <= gt_cnt + 1'b1;
                    C_EQ:    if (eq_cnt != '1) eq_cnt <= eq_cnt + 1'b1;
                    C_LT:    if (lt_cnt != '1) lt_cnt <= lt_cnt + 1'b1;
                    default: ;
                endcase
            end
        end
    end

`ifdef CMP_TALLY_ERR_CHK_EN
    // saturating tally of non-one-hot inputs
    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            err_cnt <= '0;
        else if (take && is_err && err_cnt != '1)
            err_cnt <= err_cnt + 1'b1;
    end
`else
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_cmp_tally.sv
// tb_cmp_tally: directed, table-driven bench for cmp_tally (CNT_W=8, RUN_LEN=4).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_cmp_tally;
    localparam int CNT_W = 8;
    localparam logic [1:0] GT = 2'b01, EQ = 2'b10, LT = 2'b11, ER = 2'b00;
    localparam logic [1:0] S_IDLE = 2'b00, S_TRACK = 2'b01, S_STREAK = 2'b10, S_ERR = 2'b11;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] code;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, clear;
    logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt, err_cnt;
    logic run_flag;
    logic [1:0] state;
    int n_cmp = 0;
    int n_bad = 0;

    cmp_tally_if bus();

    cmp_tally #(.CNT_W(CNT_W), .RUN_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
        .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .err_cnt(err_cnt),
        .run_flag(run_flag), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [2:0] f);
        bus.in_valid = v;
        {bus.F1, bus.F2, bus.F3} = f;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        drv(1'b0, 3'b000);
        step();
        clear = 1'b0;
    endtask

    vec_t vecs[16];
    logic [2:0] f;

    initial begin
        vecs = '{'{0,0,EQ}, '{0,1,LT}, '{0,2,LT}, '{0,3,LT},
                 '{1,0,GT}, '{1,1,EQ}, '{1,2,LT}, '{1,3,LT},
                 '{2,0,GT}, '{2,1,GT}, '{2,2,EQ}, '{2,3,LT},
                 '{3,0,GT}, '{3,1,GT}, '{3,2,GT}, '{3,3,EQ}};

        // reset
        rst_n = 1'b0; clear = 1'b0; bus.out_ready = 1'b1;
        drv(1'b0, 3'b000);
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_code", bus.out_code, 0);
        chk("rst_gt", gt_cnt, 0);
        chk("rst_eq", eq_cnt, 0);
        chk("rst_lt", lt_cnt, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_flag", run_flag, 0);
        chk("rst_state", state, S_IDLE);
        chk("rst_in_ready", bus.in_ready, 1);

        // operand sweep, one result per cycle
        for (int i = 0; i < 16; i++) begin
            f = {vecs[i].a > vecs[i].b, vecs[i].a == vecs[i].b, vecs[i].a < vecs[i].b};
            drv(1'b1, f);
            step();
            chk($sformatf("sweep%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("sweep%0d_code", i), bus.out_code, vecs[i].code);
        end
        drv(1'b0, 3'b000);
        step();
        chk("sweep_gt", gt_cnt, 6);
        chk("sweep_eq", eq_cnt, 4);
        chk("sweep_lt", lt_cnt, 6);
        chk("sweep_drain", bus.out_valid, 0);

        do_clear();
        chk("clr_gt", gt_cnt, 0);
        chk("clr_state", state, S_IDLE);

        // run of EQ results
        for (int k = 1; k <= 5; k++) begin
            drv(1'b1, 3'b010);
            step();
            chk($sformatf("run%0d_flag", k), run_flag, (k == 4) ? 1 : 0);
            chk($sformatf("run%0d_state", k), state, (k >= 4) ? S_STREAK : S_TRACK);
        end
        drv(1'b1, 3'b100);
        step();
        chk("run_gt_state", state, S_TRACK);
        chk("run_gt_flag", run_flag, 0);
        chk("run_eq_cnt", eq_cnt, 5);
        drv(1'b0, 3'b000);
        step();

        // output stall
        do_clear();
        drv(1'b1, 3'b001);
        step();
        chk("stall_pre_code", bus.out_code, LT);
        bus.out_ready = 1'b0;
        drv(1'b1, 3'b100);
        #1;
        chk("stall_in_ready", bus.in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stall%0d_code", k), bus.out_code, LT);
            chk($sformatf("stall%0d_valid", k), bus.out_valid, 1);
            chk($sformatf("stall%0d_gt", k), gt_cnt, 0);
            chk($sformatf("stall%0d_lt", k), lt_cnt, 1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", bus.in_ready, 1);
        step();
        chk("release_code", bus.out_code, GT);
        chk("release_gt", gt_cnt, 1);
        drv(1'b1, 3'b010);
        step();
        chk("b2b_code", bus.out_code, EQ);
        chk("b2b_valid", bus.out_valid, 1);
        chk("b2b_eq", eq_cnt, 1);

        // clear while stalled with a result presented
        bus.out_ready = 1'b0;
        drv(1'b1, 3'b100);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clrstall_valid", bus.out_valid, 0);
        chk("clrstall_gt", gt_cnt, 0);
        chk("clrstall_state", state, S_IDLE);
        drv(1'b0, 3'b000);
        bus.out_ready = 1'b1;
        step();

        // non-one-hot inputs
`ifdef CMP_TALLY_ERR_CHK_EN
        drv(1'b1, 3'b110);
        step();
        chk("err_cnt", err_cnt, 1);
        chk("err_code", bus.out_code, ER);
        chk("err_valid", bus.out_valid, 1);
        chk("err_state", state, S_ERR);
        drv(1'b1, 3'b100);
        step();
        chk("err_gt_cnt", gt_cnt, 1);
        chk("err_gt_code", bus.out_code, GT);
        chk("err_sticky", state, S_ERR);
        drv(1'b1, 3'b000);
        step();
        chk("err_zero_cnt", err_cnt, 2);
        do_clear();
        chk("err_clr_cnt", err_cnt, 0);
        chk("err_clr_gt", gt_cnt, 0);
        chk("err_clr_state", state, S_IDLE);
`else
        drv(1'b1, 3'b000);
        step();
        chk("drop_valid", bus.out_valid, 0);
        chk("drop_state", state, S_IDLE);
        chk("drop_err", err_cnt, 0);
        drv(1'b1, 3'b110);
        step();
        chk("prio110_code", bus.out_code, GT);
        chk("prio110_state", state, S_TRACK);
        drv(1'b1, 3'b011);
        step();
        chk("prio011_code", bus.out_code, EQ);
        drv(1'b1, 3'b111);
        step();
        chk("prio111_code", bus.out_code, GT);
        drv(1'b1, 3'b000);
        step();
        chk("drop2_valid", bus.out_valid, 0);
        chk("drop2_gt", gt_cnt, 2);
        chk("drop2_eq", eq_cnt, 1);
        chk("drop2_lt", lt_cnt, 0);
        do_clear();
`endif

        // counter saturation
        drv(1'b1, 3'b100);
        for (int k = 0; k < 254; k++) step();
        chk("sat_254", gt_cnt, 254);
        for (int k = 0; k < 6; k++) step();
        chk("sat_hold", gt_cnt, 255);
        chk("sat_state", state, S_STREAK);
        chk("sat_flag", run_flag, 0);
        drv(1'b0, 3'b000);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
